// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared opcodes, phase encodings and FSM states for the RISC sequencer
package risc_pkg;

  localparam logic [2:0] HLT = 3'b000;
  localparam logic [2:0] SKZ = 3'b001;
  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] AND = 3'b011;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] LDA = 3'b101;
  localparam logic [2:0] STO = 3'b110;
  localparam logic [2:0] JMP = 3'b111;

  localparam logic [2:0] INST_ADDR  = 3'd0;
  localparam logic [2:0] INST_FETCH = 3'd1;
  localparam logic [2:0] INST_LOAD  = 3'd2;
  localparam logic [2:0] IDLE       = 3'd3;
  localparam logic [2:0] OP_ADDR    = 3'd4;
  localparam logic [2:0] OP_FETCH   = 3'd5;
  localparam logic [2:0] ALU_OP     = 3'd6;
  localparam logic [2:0] STORE      = 3'd7;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    LOAD   = 2'd2
  } state_t;

  typedef struct packed {
    logic sel;
    logic rd;
    logic ld_ir;
    logic halt;
    logic inc_pc;
    logic ld_ac;
    logic ld_pc;
    logic wr;
    logic data_e;
  } strobes_t;

  function automatic logic is_aluop(input logic [2:0] op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/risc_ctrl_decode.sv
// rtl/risc_ctrl_decode.sv - combinational strobe generator from state, phase and latched opcode
module risc_ctrl_decode
  import risc_pkg::*;
(
  input  state_t     i_state,
  input  logic [2:0] i_phase,
  input  logic [2:0] i_op_q,
  input  logic       i_zero,
  input  logic       i_load_in,
  output strobes_t   o_strb
);

  logic w_alu;
  assign w_alu = is_aluop(i_op_q);

  always_comb begin
    o_strb = '0;
    // Program-load mode silences every strobe in the cycle it is requested.
    if (!i_load_in) begin
      case (i_state)
        RUN: begin
          case (i_phase)
            INST_ADDR:  o_strb.sel = 1'b1;
            INST_FETCH: begin o_strb.sel = 1'b1; o_strb.rd = 1'b1; end
            INST_LOAD,
            IDLE:       begin o_strb.sel = 1'b1; o_strb.rd = 1'b1; o_strb.ld_ir = 1'b1; end
            OP_ADDR: begin
              o_strb.inc_pc = 1'b1;
              o_strb.halt   = (i_op_q == HLT);
            end
            OP_FETCH:   o_strb.rd = w_alu;
            ALU_OP: begin
              o_strb.rd     = w_alu;
              o_strb.inc_pc = (i_op_q == SKZ) && i_zero;
              o_strb.ld_pc  = (i_op_q == JMP);
              o_strb.data_e = (i_op_q == STO);
            end
            default: begin
              o_strb.rd     = w_alu;
              o_strb.ld_ac  = w_alu;
              o_strb.ld_pc  = (i_op_q == JMP);
              o_strb.wr     = (i_op_q == STO);
              o_strb.data_e = (i_op_q == STO);
            end
          endcase
        end
        HALTED:  o_strb.halt = 1'b1;
        default: o_strb = '0;
      endcase
    end
  end

endmodule

// File: rtl/risc_sequencer.sv
// rtl/risc_sequencer.sv - eight-phase instruction sequencer with halt/resume, program-load hold and retire counter
module risc_sequencer
  import risc_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load_in,
  input  logic                 start,
  input  logic [2:0]           opcode,
  input  logic                 zero,
  output logic                 sel,
  output logic                 rd,
  output logic                 ld_ir,
  output logic                 halt,
  output logic                 inc_pc,
  output logic                 ld_ac,
  output logic                 ld_pc,
  output logic                 wr,
  output logic                 data_e,
  output logic [2:0]           alu_op,
  output logic [2:0]           phase,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] instr_retired
);

  state_t               r_state;
  logic [2:0]           r_phase;
  logic [2:0]           r_op_q;
  logic [CNT_WIDTH-1:0] r_retired;

  state_t     w_state_nxt;
  logic [2:0] w_phase_nxt;
  logic [2:0] w_op_nxt;
  logic       w_retire;
  strobes_t   w_strb;

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_op_nxt    = r_op_q;
    w_retire    = 1'b0;
    if (load_in) begin
      w_state_nxt = LOAD;
      w_phase_nxt = INST_ADDR;
    end else begin
      case (r_state)
        RUN: begin
          w_phase_nxt = r_phase + 3'd1;
          if (r_phase == IDLE) w_op_nxt = opcode;
          if (r_phase == STORE) w_retire = 1'b1;
          // HLT retires as it enters HALTED; PC was already bumped in OP_ADDR.
          if ((r_phase == OP_ADDR) && (r_op_q == HLT)) begin
            w_state_nxt = HALTED;
            w_phase_nxt = INST_ADDR;
            w_retire    = 1'b1;
          end
        end
        HALTED: begin
          if (start) begin
            w_state_nxt = RUN;
            w_phase_nxt = INST_ADDR;
          end
        end
        default: begin
          w_state_nxt = RUN;
          w_phase_nxt = INST_ADDR;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= RUN;
      r_phase   <= INST_ADDR;
      r_op_q    <= HLT;
      r_retired <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_phase   <= w_phase_nxt;
      r_op_q    <= w_op_nxt;
      r_retired <= r_retired + CNT_WIDTH'(w_retire);
    end
  end

  risc_ctrl_decode u_decode (
    .i_state   (r_state),
    .i_phase   (r_phase),
    .i_op_q    (r_op_q),
    .i_zero    (zero),
    .i_load_in (load_in),
    .o_strb    (w_strb)
  );

  assign sel           = w_strb.sel;
  assign rd            = w_strb.rd;
  assign ld_ir         = w_strb.ld_ir;
  assign halt          = w_strb.halt;
  assign inc_pc        = w_strb.inc_pc;
  assign ld_ac         = w_strb.ld_ac;
  assign ld_pc         = w_strb.ld_pc;
  assign wr            = w_strb.wr;
  assign data_e        = w_strb.data_e;
  assign alu_op        = r_op_q;
  assign phase         = r_phase;
  assign busy          = (r_state == RUN);
  assign instr_retired = r_retired;

endmodule

// File: doc/risc_sequencer.md
Name: risc_sequencer

Overview:
- Eight-phase instruction sequencer for the 8-bit RISC core.
- Steps each instruction through fetch, decode and execute phases.
- Drives the address-mux select, memory read/write, IR/ACC/PC load, PC increment and data-bus enable strobes.
- Owns halt/resume and program-load hold, and counts retired instructions for debug.

Parameters:
- CNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high
- load_in  input  1  external program-load mode; holds the sequencer
- start  input  1  resume pulse; leaves HALTED
- opcode  input  3  IR[7:5]; valid from phase IDLE onward
- zero  input  1  accumulator==0 flag
- sel  output  1  address mux: 1=PC, 0=IR operand
- rd  output  1  memory read
- ld_ir  output  1  load instruction register
- halt  output  1  halt indicator
- inc_pc  output  1  PC increment
- ld_ac  output  1  load accumulator
- ld_pc  output  1  load PC (jump)
- wr  output  1  memory write
- data_e  output  1  drive ACC onto data bus
- alu_op  output  3  registered opcode to the ALU
- phase  output  3  current phase (0-7) for debug
- busy  output  1  1 in phases 0-7; 0 in HALTED/LOAD
- instr_retired  output  CNT_WIDTH  retired-instruction count

Behaviour:
- Opcodes: HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111. ALUOP = ADD|AND|XOR|LDA.
- FSM states:
  - RUN with phase 0..7: INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE.
  - HALTED.
  - LOAD.
- Phase advances by 1 every clock and wraps 7->0.
- op_q (=alu_op) is captured from opcode at the end of IDLE. Phases 4-7 decode op_q only.
- Outputs are combinational from state, phase, op_q and zero. Unlisted outputs are 0.
  - INST_ADDR: sel.
  - INST_FETCH: sel, rd.
  - INST_LOAD: sel, rd, ld_ir.
  - IDLE: sel, rd, ld_ir.
  - OP_ADDR: inc_pc; halt if op_q=HLT.
  - OP_FETCH: rd if ALUOP.
  - ALU_OP: rd if ALUOP; inc_pc if SKZ&&zero; ld_pc if JMP; data_e if STO.
  - STORE: rd and ld_ac if ALUOP; ld_pc if JMP; wr and data_e if STO.
- HLT:
  - At end of OP_ADDR with op_q=HLT, go to HALTED.
  - HALTED: halt=1, all other strobes 0, busy=0.
  - start=1 in HALTED -> INST_ADDR next clock. PC was already incremented, so execution resumes at the next instruction.
  - start is ignored outside HALTED.
- Retirement:
  - instr_retired increments by 1 at the end of STORE, wrapping at 2^CNT_WIDTH.
  - HLT counts as retired on entry to HALTED.
- load_in:
  - Highest priority after reset, from any state.
  - All strobe outputs are forced to 0 combinationally in the same cycle.
  - Next clock the FSM enters LOAD. An in-flight instruction is aborted and not counted.
  - LOAD: busy=0, halt=0.
  - load_in=0 in LOAD -> INST_ADDR next clock. op_q and instr_retired are retained.
- load_in and start together: load_in wins.
- Reset (asynchronous):
  - State RUN, phase INST_ADDR, op_q=000, instr_retired=0.
  - Outputs after reset: sel=1, busy=1, phase=0, alu_op=0; all other outputs 0.
  - Reset mid-instruction aborts without a write.
- Latency: 8 clocks per instruction. Exactly one wr pulse per STO.

Decomposition:
- Shared package risc_pkg holds:
  - opcode localparams HLT..JMP;
  - phase encodings INST_ADDR..STORE;
  - FSM state encodings RUN/HALTED/LOAD.
- One natural sub-module: risc_ctrl_decode, a purely combinational strobe generator taking (state, phase, op_q, zero, load_in) as inputs.
- risc_sequencer keeps the FSM, op_q register and counter.

Test Plan:
- Reset release, opcode=ADD, zero=0:
  - sel=1 in phases 0-3; rd in 1-3; ld_ir in 2-3; inc_pc in 4; rd in 5-7; ld_ac in 7.
  - alu_op=010 from phase 4; instr_retired=1 after 8 clocks.
- STO cycle: data_e=1 in phases 6-7, wr=1 only in phase 7, rd=0 in 5-7, ld_ac=0.
- SKZ:
  - zero=1 -> inc_pc=1 in phases 4 and 6.
  - zero=0 -> inc_pc only in phase 4.
  - JMP -> ld_pc=1 in phases 6-7.
- HLT:
  - halt=1 in phase 4, then HALTED with halt=1, busy=0; no strobes for 20 clocks.
  - start pulse -> INST_ADDR next clock, sel=1.
  - instr_retired incremented once.
- load_in=1 during phase 6 of STO:
  - wr never asserts; LOAD with all strobes 0; instr_retired unchanged.
  - load_in=0 -> phase 0 next clock.
- Asynchronous reset mid-phase 5: outputs immediately sel=1, phase=0, instr_retired=0, alu_op=000, with no clock edge needed.
